// File: rtl/spi_cmd_master.sv
// Purpose : SPI mode-0 command master; sends 0..5 bytes MSB first, one cs_n pulse per byte, captures miso.
// Latency : per byte CS_SETUP + 16*SCLK_HALF + CS_HOLD + CS_GAP clk_in cycles, then one DONE cycle.
// Backpr. : none; start is only looked at in IDLE and ignored while a frame is running.
//
// Ports:
//   clk_in, sys_rst_n      clock (rising edge) and asynchronous active-low reset
//   start, cmd_len, cmd_data  frame request; length and bytes captured when start is accepted
//   miso                   serial data from slave
//   sclk, mosi, cs_n       SPI pins (sclk idles low, cs_n idles high)
//   busy, done, rx_data    status and received bytes (byte0 in [39:32], unused bytes 0)
// Optional: define SPI_MISO_SYNC_EN to put miso through a 2-flop synchronizer (needs SCLK_HALF >= 3).
module spi_cmd_master #(
  parameter int CS_SETUP  = 5,
  parameter int SCLK_HALF = 2,
  parameter int CS_HOLD   = 5,
  parameter int CS_GAP    = 5
) (
  input  logic        clk_in,
  input  logic        sys_rst_n,
  input  logic        start,
  input  logic [2:0]  cmd_len,
  input  logic [39:0] cmd_data,
  input  logic        miso,
  output logic        sclk,
  output logic        mosi,
  output logic        cs_n,
  output logic        busy,
  output logic        done,
  output logic [39:0] rx_data
);

  // Counters load duration-1 and the phase ends when they reach zero.
  localparam logic [7:0] SETUP_LD = 8'(CS_SETUP - 1);
  localparam logic [7:0] HALF_LD  = 8'(SCLK_HALF - 1);
  localparam logic [7:0] HOLD_LD  = 8'(CS_HOLD - 1);
  localparam logic [7:0] GAP_LD   = 8'(CS_GAP - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, BIT_LOW, BIT_HIGH, HOLD, GAP, DONE
  } state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [2:0]  bit_cnt;
  logic [2:0]  bytes_left;
  logic [39:0] tx_sh;
  logic [5:0]  rx_pos;
  logic [2:0]  len_clamped;
  logic        miso_s;

  assign len_clamped = (cmd_len > 3'd5) ? 3'd5 : cmd_len;

`ifdef SPI_MISO_SYNC_EN
  logic [1:0] miso_sync;

  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) miso_sync <= 2'b00;
    else            miso_sync <= {miso_sync[0], miso};
  end

  assign miso_s = miso_sync[1];

  // Two cycles of synchronizer delay must fit inside the sclk-low half period.
  if (SCLK_HALF < 3) begin : g_half_too_short
    $error("SPI_MISO_SYNC_EN requires SCLK_HALF >= 3");
  end
`else
  assign miso_s = miso;
`endif

  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      bytes_left <= '0;
      tx_sh      <= '0;
      rx_pos     <= '0;
      rx_data    <= '0;
      sclk       <= 1'b0;
      mosi       <= 1'b0;
      cs_n       <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tx_sh   <= cmd_data;
            rx_data <= '0;
            rx_pos  <= 6'd39;
            if (len_clamped == 3'd0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state      <= SETUP;
              busy       <= 1'b1;
              cs_n       <= 1'b0;
              cnt        <= SETUP_LD;
              bytes_left <= len_clamped;
            end
          end
        end

        SETUP: begin
          if (cnt == 8'd0) begin
            state   <= BIT_LOW;
            mosi    <= tx_sh[39];
            tx_sh   <= {tx_sh[38:0], 1'b0};
            bit_cnt <= 3'd7;
            cnt     <= HALF_LD;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        BIT_LOW: begin
          if (cnt == 8'd0) begin
            // The edge that raises sclk is the miso sampling edge.
            state           <= BIT_HIGH;
            sclk            <= 1'b1;
            rx_data[rx_pos] <= miso_s;
            rx_pos          <= rx_pos - 6'd1;
            cnt             <= HALF_LD;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        BIT_HIGH: begin
          if (cnt == 8'd0) begin
            sclk <= 1'b0;
            if (bit_cnt == 3'd0) begin
              state <= HOLD;
              mosi  <= 1'b0;
              cnt   <= HOLD_LD;
            end else begin
              state   <= BIT_LOW;
              bit_cnt <= bit_cnt - 3'd1;
              mosi    <= tx_sh[39];
              tx_sh   <= {tx_sh[38:0], 1'b0};
              cnt     <= HALF_LD;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        HOLD: begin
          if (cnt == 8'd0) begin
            state <= GAP;
            cs_n  <= 1'b1;
            cnt   <= GAP_LD;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        GAP: begin
          if (cnt == 8'd0) begin
            if (bytes_left == 3'd1) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state      <= SETUP;
              bytes_left <= bytes_left - 3'd1;
              cs_n       <= 1'b0;
              cnt        <= SETUP_LD;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          sclk  <= 1'b0;
          mosi  <= 1'b0;
          cs_n  <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_master.sv
module tb_spi_cmd_master;

  localparam int S    = 5;
  localparam int H    = 2;
  localparam int HO   = 5;
  localparam int G    = 5;
  localparam int BYTE = S + 16 * H + HO + G;

  logic        clk_in = 1'b0;
  logic        sys_rst_n;
  logic        start;
  logic [2:0]  cmd_len;
  logic [39:0] cmd_data;
  logic        miso;
  logic        sclk, mosi, cs_n, busy, done;
  logic [39:0] rx_data;

  int vectors = 0;
  int fails   = 0;

  // Slave model: presents bit (7 - sl_bit) of slv[sl_byte] before each sclk rise.
  logic [7:0] slv [5];
  int sl_bit  = 0;
  int sl_byte = 0;

  spi_cmd_master #(
    .CS_SETUP (S),
    .SCLK_HALF(H),
    .CS_HOLD  (HO),
    .CS_GAP   (G)
  ) dut (
    .clk_in   (clk_in),
    .sys_rst_n(sys_rst_n),
    .start    (start),
    .cmd_len  (cmd_len),
    .cmd_data (cmd_data),
    .miso     (miso),
    .sclk     (sclk),
    .mosi     (mosi),
    .cs_n     (cs_n),
    .busy     (busy),
    .done     (done),
    .rx_data  (rx_data)
  );

  always #10 clk_in = ~clk_in;

  always @(negedge cs_n) sl_bit = 0;
  always @(posedge sclk) sl_bit = sl_bit + 1;
  always @(posedge cs_n) sl_byte = sl_byte + 1;

  always @* begin
    miso = 1'b0;
    if (sl_bit < 8 && sl_byte < 5) miso = slv[sl_byte][7 - sl_bit];
  end

  // Expected {cs_n, sclk, mosi, busy, done} in cycle k after the start-accepting edge.
  function automatic logic [4:0] exp_pins(input int k, input int lc, input logic [39:0] d);
    int t, b, bi;
    bit ph;
    logic [7:0] by;
    if (k == lc * BYTE + 1) return 5'b10001;
    if (k > lc * BYTE + 1)  return 5'b10000;
    b  = (k - 1) / BYTE;
    t  = (k - 1) % BYTE;
    by = d[39 - 8 * b -: 8];
    if (t < S) return 5'b00010;
    if (t < S + 16 * H) begin
      bi = (t - S) / (2 * H);
      ph = ((t - S) % (2 * H)) >= H;
      return {1'b0, ph, by[7 - bi], 1'b1, 1'b0};
    end
    if (t < S + 16 * H + HO) return 5'b00010;
    return 5'b10010;
  endfunction

  task automatic randomize_slave();
    for (int i = 0; i < 5; i++) slv[i] = 8'($urandom_range(0, 255));
  endtask

  // Runs one frame, checking pins every cycle; abort_k > 0 returns at that cycle unchecked.
  task automatic run_frame(input logic [2:0] len, input logic [39:0] data,
                           input bit mid_start, input int abort_k);
    int lc, total;
    logic [39:0] exp_rx;
    logic [4:0] got, exp;
    lc    = (len > 3'd5) ? 5 : int'(len);
    total = lc * BYTE;
    exp_rx = '0;
    for (int i = 0; i < lc; i++) exp_rx[39 - 8 * i -: 8] = slv[i];
    sl_byte = 0;
    sl_bit  = 0;
    @(negedge clk_in);
    start = 1'b1; cmd_len = len; cmd_data = data;
    @(negedge clk_in);
    start = 1'b0;
    cmd_len  = 3'($urandom_range(0, 7));
    cmd_data = {8'($urandom), $urandom};
    for (int k = 1; k <= total + 2; k++) begin
      if (k == abort_k) begin
        start = 1'b0;
        return;
      end
      got = {cs_n, sclk, mosi, busy, done};
      exp = exp_pins(k, lc, data);
      vectors++;
      if (got !== exp) begin
        fails++;
        $display("FAIL pins len=%0d k=%0d {cs_n,sclk,mosi,busy,done} got %b want %b", len, k, got, exp);
      end
      if (k == 1) begin
        vectors++;
        if (rx_data !== 40'h0) begin
          fails++;
          $display("FAIL rx_clear_on_start got %h want 0", rx_data);
        end
      end
      if (k == total + 1) begin
        vectors++;
        if (rx_data !== exp_rx) begin
          fails++;
          $display("FAIL rx_at_done len=%0d got %h want %h", len, rx_data, exp_rx);
        end
      end
      if (mid_start && k <= total + 1 && $urandom_range(0, 7) == 0) begin
        start    = 1'b1;
        cmd_len  = 3'($urandom_range(0, 7));
        cmd_data = {8'($urandom), $urandom};
      end else begin
        start = 1'b0;
      end
      @(negedge clk_in);
    end
    start = 1'b0;
    vectors++;
    if (rx_data !== exp_rx || busy !== 1'b0) begin
      fails++;
      $display("FAIL rx_stable_idle got rx=%h busy=%b want rx=%h busy=0", rx_data, busy, exp_rx);
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0; start = 1'b0; cmd_len = '0; cmd_data = '0;
    repeat (3) @(negedge clk_in);
    vectors++;
    if ({cs_n, sclk, mosi, busy, done} !== 5'b10000 || rx_data !== 40'h0) begin
      fails++;
      $display("FAIL reset_state got pins=%b rx=%h want pins=10000 rx=0",
               {cs_n, sclk, mosi, busy, done}, rx_data);
    end
    sys_rst_n = 1'b1;
    repeat (2) @(negedge clk_in);
    vectors++;
    if ({cs_n, sclk, mosi, busy, done} !== 5'b10000) begin
      fails++;
      $display("FAIL idle_after_release got %b want 10000", {cs_n, sclk, mosi, busy, done});
    end
  endtask

  task automatic test_three_byte();
    randomize_slave();
    run_frame(3'd3, {24'h916400, 16'($urandom)}, 1'b0, 0);
  endtask

  task automatic test_single_byte();
    randomize_slave();
    run_frame(3'd1, {8'h06, $urandom}, 1'b0, 0);
  endtask

  task automatic test_five_byte_rx();
    slv[0] = 8'hA5; slv[1] = 8'h5A; slv[2] = 8'hFF; slv[3] = 8'h00; slv[4] = 8'h3C;
    run_frame(3'd5, {8'($urandom), $urandom}, 1'b0, 0);
  endtask

  task automatic test_mid_start();
    for (int n = 0; n < 3; n++) begin
      randomize_slave();
      run_frame(3'($urandom_range(1, 5)), {8'($urandom), $urandom}, 1'b1, 0);
    end
  endtask

  task automatic test_len_zero();
    randomize_slave();
    run_frame(3'd0, {8'($urandom), $urandom}, 1'b0, 0);
  endtask

  task automatic test_len_clamp();
    randomize_slave();
    run_frame(3'd6, {8'($urandom), $urandom}, 1'b0, 0);
    randomize_slave();
    run_frame(3'd7, {8'($urandom), $urandom}, 1'b1, 0);
  endtask

  task automatic test_reset_midframe();
    randomize_slave();
    // Cycle 71: byte index 1, bit 4 (from MSB), sclk-high half.
    run_frame(3'd3, {8'($urandom), $urandom}, 1'b0, BYTE + S + 4 * 2 * H + H + 1);
    vectors++;
    if (sclk !== 1'b1 || cs_n !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_position got sclk=%b cs_n=%b busy=%b want 1 0 1", sclk, cs_n, busy);
    end
    #3 sys_rst_n = 1'b0;
    #1;
    vectors++;
    if ({cs_n, sclk, mosi, busy, done} !== 5'b10000 || rx_data !== 40'h0) begin
      fails++;
      $display("FAIL async_reset got pins=%b rx=%h want pins=10000 rx=0",
               {cs_n, sclk, mosi, busy, done}, rx_data);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold cyc=%0d got done=%b busy=%b want 0 0", i, done, busy);
      end
    end
    sys_rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_in);
      vectors++;
      if ({cs_n, sclk, mosi, busy, done} !== 5'b10000) begin
        fails++;
        $display("FAIL idle_after_abort cyc=%0d got %b want 10000", i, {cs_n, sclk, mosi, busy, done});
      end
    end
    randomize_slave();
    run_frame(3'd2, {8'($urandom), $urandom}, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) begin
      randomize_slave();
      run_frame(3'($urandom_range(0, 7)), {8'($urandom), $urandom}, 1'($urandom_range(0, 1)), 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_three_byte();
    test_single_byte();
    test_five_byte_rx();
    test_mid_start();
    test_len_zero();
    test_len_clamp();
    test_reset_midframe();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/spi_cmd_master.md
SPI_CMD_MASTER -- requirements
Module: spi_cmd_master

Interface
REQ-001 SHALL have parameter CS_SETUP, default 5, meaning clk_in cycles from cs_n low to first bit (range 1..255).
REQ-002 SHALL have parameter SCLK_HALF, default 2, meaning clk_in cycles per sclk half-period (range 1..255).
REQ-003 SHALL have parameter CS_HOLD, default 5, meaning cycles from the last sclk falling edge to cs_n high (range 1..255).
REQ-004 SHALL have parameter CS_GAP, default 5, meaning cs_n-high cycles between bytes (range 1..255).
REQ-005 SHALL have port clk_in  input  1  system clock, 50 MHz, all logic on rising edge.
REQ-006 SHALL have port sys_rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port start  input  1  frame request, sampled only in IDLE.
REQ-008 SHALL have port cmd_len  input  3  byte count of frame, captured at start.
REQ-009 SHALL have port cmd_data  input  40  frame bytes, byte0 in [39:32], captured at start.
REQ-010 SHALL have port miso  input  1  serial data from slave.
REQ-011 SHALL have port sclk  output  1  SPI clock, idle low.
REQ-012 SHALL have port mosi  output  1  serial data to slave, MSB first.
REQ-013 SHALL have port cs_n  output  1  slave select, low for the duration of each byte.
REQ-014 SHALL have port busy  output  1  high from the cycle after start is accepted until done.
REQ-015 SHALL have port done  output  1  one-cycle pulse at frame end.
REQ-016 SHALL have port rx_data  output  40  miso bytes, byte0 in [39:32], unused bytes 0.

Function
REQ-017 SHALL implement states IDLE, SETUP, BIT_LOW, BIT_HIGH, HOLD, GAP, DONE.
REQ-018 SHALL accept start only in IDLE; start in any other state is ignored.
REQ-019 SHALL clamp cmd_len above 5 to 5; cmd_len 0 goes IDLE->DONE with no cs_n or sclk activity.
REQ-020 SHALL per byte: drive cs_n low with sclk low for CS_SETUP cycles (SETUP).
REQ-021 SHALL per bit: update mosi on BIT_LOW entry and hold sclk low for SCLK_HALF cycles, then sclk high for SCLK_HALF cycles (BIT_HIGH); sample miso on the clk_in edge that drives sclk high.
REQ-022 SHALL after bit 0: hold cs_n low and sclk low for CS_HOLD cycles (HOLD), then cs_n high for CS_GAP cycles (GAP).
REQ-023 SHALL frame bytes individually: cs_n returns high between every byte (one cs_n pulse per byte).
REQ-024 SHALL time each byte at CS_SETUP + 16*SCLK_HALF + CS_HOLD + CS_GAP cycles; 47 cycles at default parameters.
REQ-025 SHALL after the last GAP enter DONE for one cycle: done=1, busy=0 in that cycle, rx_data final and stable until the next accepted start.
REQ-026 SHALL clear rx_data to 0 on start acceptance.
REQ-027 SHALL drive mosi 0 outside BIT_LOW/BIT_HIGH.

Reset
REQ-028 SHALL on sys_rst_n low, immediately (asynchronously) force state IDLE, sclk=0, mosi=0, cs_n=1, busy=0, done=0, rx_data=0, all counters 0.
REQ-029 SHALL abort an in-progress frame on reset without emitting done; after release, remain in IDLE until a new start.

Configuration
REQ-030 SHALL honour macro SPI_MISO_SYNC_EN: when defined, miso passes through a 2-flop synchronizer before sampling, and SCLK_HALF SHALL be at least 3; when undefined, miso is sampled directly.
REQ-031 SHALL keep all other timing identical with or without SPI_MISO_SYNC_EN.

Verification
REQ-032 SHALL cover: cmd_len=3, cmd_data=0x91_64_00_xx_xx, start -> three cs_n low pulses, mosi bit streams 10010001/01100100/00000000, done 141 cycles after busy rises.
REQ-033 SHALL cover: cmd_len=1, cmd_data[39:32]=0x06 -> single byte, done at cycle 47, busy low in the done cycle.
REQ-034 SHALL cover: cmd_len=5 with slave model returning 0xA5,0x5A,0xFF,0x00,0x3C on miso -> rx_data=0xA55AFF003C at done.
REQ-035 SHALL cover: start re-asserted mid-frame, and cmd_len=0 -> mid-frame start ignored, no output glitch; cmd_len=0 gives done 1 cycle after start with cs_n high throughout.
REQ-036 SHALL cover: sys_rst_n low during bit 4 of byte 2 -> cs_n=1, sclk=0, busy=0 same cycle, no done pulse; fresh frame after release completes correctly.
